tcdm_burst_rsp_ungrouper: RTL and testbench

Receiving-side counterpart of the response grouper on the TCDM burst response channel. It sits at the initiator end of the remote-load response path. It detects a grouped response on lane 0 (`gdata.valid` set) and expands it back into `RspGF` individual per-lane responses. Each expanded lane is handed downstream with its own valid/ready handshake. Ungrouped responses pass through unchanged; a one-entry expansion buffer with a per-lane pending mask absorbs downstream back-pressure.

---
 rtl/tcdm_burst_rsp_ungrouper.sv | 119 +++++++++++
 tb/tb_tcdm_burst_rsp_ungrouper.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_burst_rsp_ungrouper.sv
// Expands grouped TCDM burst responses arriving on lane 0 back into per-lane responses.
// Ungrouped responses pass straight through; a one-entry buffer absorbs downstream stalls.
package tcdm_burst_rsp_ungrouper_pkg;
  typedef logic [31:0] default_rdata_t;
  typedef struct packed {
    logic                valid;
    default_rdata_t [0:0] data;
  } default_gdata_t;
  typedef struct packed {
    logic           wen;
    default_rdata_t rdata;
    default_gdata_t gdata;
  } default_rsp_payload_t;
endpackage

module tcdm_burst_rsp_ungrouper #(
  parameter int unsigned RspGF = 2,
  parameter type addr_t = logic,
  parameter type rsp_payload_t = tcdm_burst_rsp_ungrouper_pkg::default_rsp_payload_t
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  rsp_payload_t rsp_payload_i [RspGF],
  input  addr_t        rsp_addr_i    [RspGF],
  input  logic [RspGF-1:0] rsp_wide_i,
  input  logic [RspGF-1:0] rsp_valid_i,
  output logic [RspGF-1:0] rsp_ready_o,
  output rsp_payload_t rsp_payload_o [RspGF],
  output addr_t        rsp_addr_o    [RspGF],
  output logic [RspGF-1:0] rsp_wide_o,
  output logic [RspGF-1:0] rsp_valid_o,
  input  logic [RspGF-1:0] rsp_ready_i,
  output logic         busy_o
);

  if (RspGF < 2 || (RspGF & (RspGF - 1)) != 0) begin : g_bad_gf
    $error("tcdm_burst_rsp_ungrouper: RspGF must be a power of two >= 2");
  end

  rsp_payload_t     buf_payload [RspGF];
  addr_t            buf_addr;
  logic             buf_wide;
  logic [RspGF-1:0] pending;
  logic [RspGF-1:0] pending_d;
  rsp_payload_t     cap_payload [RspGF];
  logic             empty;
  logic             grp;
  logic             cap_ok;
  logic             capture;

  assign empty   = (pending == '0);
  assign busy_o  = ~empty;
  assign grp     = rsp_valid_i[0] & rsp_payload_i[0].gdata.valid;
  // A grouped response may overwrite the buffer only if every still-pending lane leaves this edge.
  assign cap_ok  = empty | ((pending & ~rsp_ready_i) == '0);
  assign capture = grp & cap_ok;

  always_comb begin
    cap_payload[0]       = rsp_payload_i[0];
    cap_payload[0].gdata = '0;
  end

  for (genvar g = 1; g < RspGF; g++) begin : g_split
    always_comb begin
      cap_payload[g]       = rsp_payload_i[0];
      cap_payload[g].rdata = rsp_payload_i[0].gdata.data[g-1];
      cap_payload[g].gdata = '0;
    end
  end

  always_comb begin
    pending_d = pending & ~rsp_ready_i;
    if (capture) begin
      pending_d = '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending     <= '0;
      buf_payload <= '{default: '0};
      buf_addr    <= '0;
      buf_wide    <= 1'b0;
    end else begin
      pending <= pending_d;
      if (capture) begin
        buf_payload <= cap_payload;
        buf_addr    <= rsp_addr_i[0];
        buf_wide    <= rsp_wide_i[0];
      end
    end
  end

  // Handshake: a lane transfers on a cycle where valid and ready are both high; a valid
  // lane holds its payload stable until accepted, and ready never depends on a lane's own
  // valid except lane 0, whose ready reflects whether a grouped capture can happen.
  always_comb begin
    rsp_valid_o   = '0;
    rsp_ready_o   = '0;
    rsp_payload_o = rsp_payload_i;
    rsp_addr_o    = rsp_addr_i;
    rsp_wide_o    = rsp_wide_i;
    if (!empty) begin
      rsp_valid_o    = pending;
      rsp_ready_o[0] = capture;
      rsp_wide_o     = {RspGF{buf_wide}};
      for (int i = 0; i < RspGF; i++) begin
        rsp_payload_o[i] = buf_payload[i];
        rsp_addr_o[i]    = buf_addr;
      end
    end else if (grp) begin
      rsp_ready_o[0] = 1'b1;
    end else begin
      rsp_valid_o = rsp_valid_i;
      rsp_ready_o = rsp_ready_i;
    end
  end

endmodule

// File: tb/tb_tcdm_burst_rsp_ungrouper.sv
// Directed bench for tcdm_burst_rsp_ungrouper with four lanes: pass-through, grouped
// expansion, partial/stalled drains, back-to-back capture, blocked capture and async reset.
module tb_tcdm_burst_rsp_ungrouper;

  localparam int GF = 4;

  typedef logic [15:0] rdata_t;
  typedef logic [7:0]  addr_t;
  typedef struct packed {
    logic                valid;
    rdata_t [GF-2:0]     data;
  } gdata_t;
  typedef struct packed {
    logic   wen;
    rdata_t rdata;
    gdata_t gdata;
  } rsp_t;

  logic          clk;
  logic          rst_n;
  rsp_t          pay_i  [GF];
  addr_t         addr_i [GF];
  logic [GF-1:0] wide_i;
  logic [GF-1:0] valid_i;
  logic [GF-1:0] ready_o;
  rsp_t          pay_o  [GF];
  addr_t         addr_o [GF];
  logic [GF-1:0] wide_o;
  logic [GF-1:0] valid_o;
  logic [GF-1:0] ready_i;
  logic          busy;

  int checks = 0;
  int errors = 0;

  tcdm_burst_rsp_ungrouper #(
    .RspGF(GF),
    .addr_t(addr_t),
    .rsp_payload_t(rsp_t)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .rsp_payload_i(pay_i),
    .rsp_addr_i(addr_i),
    .rsp_wide_i(wide_i),
    .rsp_valid_i(valid_i),
    .rsp_ready_o(ready_o),
    .rsp_payload_o(pay_o),
    .rsp_addr_o(addr_o),
    .rsp_wide_o(wide_o),
    .rsp_valid_o(valid_o),
    .rsp_ready_i(ready_i),
    .busy_o(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rsp_t ung(input rdata_t d, input logic w);
    rsp_t r;
    r       = '0;
    r.wen   = w;
    r.rdata = d;
    return r;
  endfunction

  function automatic rsp_t grp(input rdata_t d0, input rdata_t d1, input rdata_t d2, input rdata_t d3);
    rsp_t r;
    r                 = '0;
    r.rdata           = d0;
    r.gdata.valid     = 1'b1;
    r.gdata.data[0]   = d1;
    r.gdata.data[1]   = d2;
    r.gdata.data[2]   = d3;
    return r;
  endfunction

  // driver tasks
  task automatic set_idle();
    for (int k = 0; k < GF; k++) begin
      pay_i[k]  = '0;
      addr_i[k] = '0;
    end
    wide_i  = '0;
    valid_i = '0;
    ready_i = '0;
  endtask

  task automatic send_grp(input rdata_t base, input addr_t a, input logic w);
    set_idle();
    pay_i[0]  = grp(base, base + 16'd1, base + 16'd2, base + 16'd3);
    addr_i[0] = a;
    wide_i[0] = w;
    valid_i   = 4'b0001;
  endtask

  task automatic chk_lane_rdata(input string tag, input rdata_t base);
    for (int i = 0; i < GF; i++) begin
      chk($sformatf("%s_rdata%0d", tag, i), 64'(pay_o[i].rdata), 64'(base + rdata_t'(i)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    tick();
    rst_n = 1'b1;

    // pass-through, all lanes, lane 2 a store
    for (int k = 0; k < GF; k++) begin
      pay_i[k]  = ung(16'hA0 + rdata_t'(k), k == 2);
      addr_i[k] = addr_t'(k + 1);
    end
    wide_i  = 4'b0101;
    valid_i = 4'hF;
    ready_i = 4'hF;
    @(negedge clk);
    chk("pt_valid", 64'(valid_o), 64'hF);
    chk("pt_ready", 64'(ready_o), 64'hF);
    chk_lane_rdata("pt", 16'hA0);
    chk("pt_addr3", 64'(addr_o[3]), 64'd4);
    chk("pt_wide", 64'(wide_o), 64'b0101);
    chk("pt_wen2", 64'(pay_o[2].wen), 64'd1);
    chk("pt_busy", 64'(busy), 64'd0);
    tick();
    ready_i = 4'b0011;
    @(negedge clk);
    chk("pt_part_ready", 64'(ready_o), 64'b0011);
    chk("pt_busy2", 64'(busy), 64'd0);
    tick();

    // grouped, all ready
    send_grp(16'h10, 8'h5, 1'b1);
    ready_i = 4'hF;
    @(negedge clk);
    chk("g1_cap_valid", 64'(valid_o), 64'd0);
    chk("g1_cap_ready", 64'(ready_o), 64'b0001);
    chk("g1_cap_busy", 64'(busy), 64'd0);
    tick();
    set_idle();
    ready_i = 4'hF;
    @(negedge clk);
    chk("g1_valid", 64'(valid_o), 64'hF);
    chk("g1_busy", 64'(busy), 64'd1);
    chk_lane_rdata("g1", 16'h10);
    for (int i = 0; i < GF; i++) begin
      chk($sformatf("g1_addr%0d", i), 64'(addr_o[i]), 64'h5);
      chk($sformatf("g1_gdata%0d", i), 64'(pay_o[i].gdata), 64'd0);
    end
    chk("g1_wide", 64'(wide_o), 64'hF);
    chk("g1_ready", 64'(ready_o), 64'd0);
    tick();
    @(negedge clk);
    chk("g1_done_busy", 64'(busy), 64'd0);
    chk("g1_done_valid", 64'(valid_o), 64'd0);
    tick();

    // grouped, split drain 0101 then 1010
    send_grp(16'h10, 8'h5, 1'b0);
    ready_i = 4'hF;
    tick();
    set_idle();
    ready_i = 4'b0101;
    @(negedge clk);
    chk("sp_c1_valid", 64'(valid_o), 64'hF);
    chk("sp_c1_ready", 64'(ready_o), 64'd0);
    tick();
    ready_i = 4'b1010;
    @(negedge clk);
    chk("sp_c2_valid", 64'(valid_o), 64'b1010);
    chk("sp_c2_busy", 64'(busy), 64'd1);
    chk("sp_c2_rdata1", 64'(pay_o[1].rdata), 64'h11);
    chk("sp_c2_rdata3", 64'(pay_o[3].rdata), 64'h13);
    tick();
    set_idle();
    @(negedge clk);
    chk("sp_done_busy", 64'(busy), 64'd0);
    chk("sp_done_valid", 64'(valid_o), 64'd0);
    tick();

    // back-to-back grouped, all ready
    send_grp(16'h20, 8'h6, 1'b0);
    ready_i = 4'hF;
    tick();
    send_grp(16'h30, 8'h7, 1'b0);
    ready_i = 4'hF;
    @(negedge clk);
    chk("bb_a_valid", 64'(valid_o), 64'hF);
    chk("bb_a_ready", 64'(ready_o), 64'b0001);
    chk_lane_rdata("bb_a", 16'h20);
    tick();
    set_idle();
    ready_i = 4'hF;
    @(negedge clk);
    chk("bb_b_valid", 64'(valid_o), 64'hF);
    chk("bb_b_busy", 64'(busy), 64'd1);
    chk("bb_b_addr2", 64'(addr_o[2]), 64'h7);
    chk_lane_rdata("bb_b", 16'h30);
    tick();
    @(negedge clk);
    chk("bb_done_busy", 64'(busy), 64'd0);
    tick();

    // lane 3 stalled while an ungrouped lane-1 response waits
    send_grp(16'h40, 8'h8, 1'b0);
    ready_i = 4'hF;
    tick();
    set_idle();
    pay_i[1]  = ung(16'h77, 1'b0);
    addr_i[1] = 8'h9;
    valid_i   = 4'b0010;
    ready_i   = 4'b0111;
    @(negedge clk);
    chk("st_c1_valid", 64'(valid_o), 64'hF);
    chk("st_c1_ready", 64'(ready_o), 64'd0);
    tick();
    @(negedge clk);
    chk("st_c2_valid", 64'(valid_o), 64'b1000);
    chk("st_c2_ready", 64'(ready_o), 64'd0);
    chk("st_c2_rdata3", 64'(pay_o[3].rdata), 64'h43);
    tick();
    ready_i = 4'hF;
    @(negedge clk);
    chk("st_c3_valid", 64'(valid_o), 64'b1000);
    chk("st_c3_ready", 64'(ready_o), 64'd0);
    tick();
    @(negedge clk);
    chk("st_c4_valid", 64'(valid_o), 64'b0010);
    chk("st_c4_rdata1", 64'(pay_o[1].rdata), 64'h77);
    chk("st_c4_ready", 64'(ready_o), 64'hF);
    chk("st_c4_busy", 64'(busy), 64'd0);
    tick();

    // grouped input blocked while a lane it would overwrite is still pending
    send_grp(16'h50, 8'h1, 1'b0);
    ready_i = 4'hF;
    tick();
    send_grp(16'h60, 8'h2, 1'b0);
    ready_i = 4'b1110;
    @(negedge clk);
    chk("bl_c1_ready", 64'(ready_o), 64'd0);
    chk("bl_c1_valid", 64'(valid_o), 64'hF);
    tick();
    ready_i = 4'b0001;
    @(negedge clk);
    chk("bl_c2_valid", 64'(valid_o), 64'b0001);
    chk("bl_c2_ready", 64'(ready_o), 64'b0001);
    chk("bl_c2_rdata0", 64'(pay_o[0].rdata), 64'h50);
    tick();
    set_idle();
    ready_i = 4'hF;
    @(negedge clk);
    chk("bl_c3_valid", 64'(valid_o), 64'hF);
    chk("bl_c3_rdata2", 64'(pay_o[2].rdata), 64'h62);
    chk("bl_c3_addr1", 64'(addr_o[1]), 64'h2);
    tick();

    // async reset with pending = 0110
    send_grp(16'h70, 8'h3, 1'b0);
    ready_i = 4'hF;
    tick();
    set_idle();
    ready_i = 4'b1001;
    tick();
    ready_i = 4'b0000;
    @(negedge clk);
    chk("rs_pre_valid", 64'(valid_o), 64'b0110);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_async_valid", 64'(valid_o), 64'd0);
    chk("rs_async_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    pay_i[2]  = ung(16'hBB, 1'b0);
    valid_i   = 4'b0100;
    ready_i   = 4'hF;
    @(negedge clk);
    chk("rs_pt_valid", 64'(valid_o), 64'b0100);
    chk("rs_pt_rdata2", 64'(pay_o[2].rdata), 64'hBB);
    tick();
    set_idle();
    @(negedge clk);
    chk("rs_idle_valid", 64'(valid_o), 64'd0);
    chk("rs_idle_busy", 64'(busy), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
